// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem req/ack channel, decode valid/ready channel and redirect.
// The master modport is the fetch unit's view; slave is memory/decode/branch side.
interface fetch_unit_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              dec_valid;
  logic [INST_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    input  imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    output imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, one outstanding imem request, instruction queue to decode.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module fetch_unit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state, state_nxt;
  logic              req, req_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] pc_inc, redir_pc;
  logic              push, pop;

  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt, count_popped;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;

  logic              vld_p1;
  logic [INST_W-1:0] inst_p1;
  logic [ADDR_W-1:0] pc_p1;

  assign redir_pc     = bus.redirect_pc & ~ADDR_W'(3);
  assign pc_inc       = fetch_pc + ADDR_W'(4);
  assign pop          = vld_p1 & bus.dec_ready;
  assign count_popped = count - CNT_W'(pop);
  assign wr_ptr       = rd_ptr + count[PTR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      req      <= req_nxt;
      addr     <= addr_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_nxt      = req;
    addr_nxt     = addr;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_nxt = redir_pc;
        end else if (count < CNT_W'(DEPTH)) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_nxt = redir_pc;
          // An in-flight request cannot be retracted; a same-cycle ack just retargets.
          if (bus.imem_ack) addr_nxt = redir_pc;
          else              state_nxt = DROP;
        end else if (bus.imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = pc_inc;
          if ((count_popped + CNT_W'(1)) < CNT_W'(DEPTH)) begin
            addr_nxt = pc_inc;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_nxt = redir_pc;
        if (bus.imem_ack) begin
          state_nxt = WAIT;
          addr_nxt  = fetch_pc_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign count_nxt  = bus.redirect ? '0 : (count_popped + CNT_W'(push));
  assign head_inst  = (count_popped == '0) ? bus.imem_rdata : mem_inst[rd_ptr_nxt];
  assign head_pc    = (count_popped == '0) ? fetch_pc : mem_pc[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= bus.imem_rdata;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

  // p1: registered queue head toward decode; inst/pc hold while the queue is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      pc_p1   <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      vld_p1 <= (count_nxt != '0);
      if (count_nxt != '0) begin
        inst_p1 <= head_inst;
        pc_p1   <= head_pc;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.dec_valid = vld_p1;
  assign bus.dec_inst  = inst_p1;
  assign bus.dec_pc    = pc_p1;

`ifdef FETCH_STATS_EN
  logic        drop_rsp;
  logic [31:0] flush_cnt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign drop_rsp  = bus.imem_ack & (((state == WAIT) & bus.redirect) | (state == DROP));
  assign flush_cnt = (bus.redirect ? 32'(count_popped) : 32'd0) + 32'(drop_rsp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= sat_add(stat_fetched, 32'(push));
      stat_flushed <= sat_add(stat_flushed, flush_cnt);
    end
  end
`endif

endmodule
